// File: rtl/error_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : error_window_ctrl
// Purpose  : Measurement-window sequencer and result reader for the receiver
//            error accumulator. Counts 2^LOG2_M symbol enables per window,
//            strobes the accumulator clear/latch, captures the window mean and
//            mean-square, computes the variance and presents the results on
//            a valid/ready interface.
// Ports    : clk, reset (sync, active-high)
//            sym_clk_ena  - one-clk symbol strobe
//            start        - level; 1 = run windows back to back
//            accumulated_error / accumulated_squared_error - accumulator outputs
//            clear_accumulator - accumulator clear/latch strobe
//            shiftVal     - constant LOG2_M
//            mean_error / mean_sq_error / error_variance - captured results
//            stats_valid / stats_ready - result handshake
//            window_count - captured windows since reset (wraps)
//            overrun      - sticky: a capture overwrote an unread result
// Revision : 1.0 - initial release
// ============================================================================
module error_window_ctrl #(
  parameter int LOG2_M     = 10,
  parameter int ACC_SETTLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sym_clk_ena,
  input  logic        start,
  input  logic [17:0] accumulated_error,
  input  logic [35:0] accumulated_squared_error,
  output logic        clear_accumulator,
  output logic [7:0]  shiftVal,
  output logic [17:0] mean_error,
  output logic [35:0] mean_sq_error,
  output logic [35:0] error_variance,
  output logic        stats_valid,
  input  logic        stats_ready,
  output logic [15:0] window_count,
  output logic        overrun
);

  localparam int                CNT_W       = LOG2_M + 1;
  localparam logic [CNT_W-1:0]  WIN_LEN     = {1'b1, {LOG2_M{1'b0}}};
  localparam int                SET_W       = (ACC_SETTLE > 1) ? $clog2(ACC_SETTLE) : 1;
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(ACC_SETTLE - 1);
  localparam logic [7:0]        SHIFT_VAL   = 8'(LOG2_M);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRIME   = 3'd1,
    ST_ACCUM   = 3'd2,
    ST_CLOSE   = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_CAPTURE = 3'd5
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] sym_cnt, sym_cnt_next, sym_cnt_inc;
  logic [SET_W-1:0] settle_cnt, settle_next;
  logic             capture;
  logic             abort;

  // Variance datapath
  logic [35:0] err_ext;
  logic [35:0] err_square;
  logic [36:0] var_diff;
  logic [35:0] var_clamped;

  assign shiftVal = SHIFT_VAL;

  // Saturating symbol count: with very short windows several enables can land
  // in SETTLE/CAPTURE; the count must never wrap past a full window.
  assign sym_cnt_inc = (sym_clk_ena && (sym_cnt != WIN_LEN)) ? sym_cnt + 1'b1 : sym_cnt;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      sym_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= state_next;
      sym_cnt    <= sym_cnt_next;
      settle_cnt <= settle_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and controls
  // --------------------------------------------------------------------------
  always_comb begin
    state_next        = state;
    sym_cnt_next      = sym_cnt;
    settle_next       = settle_cnt;
    clear_accumulator = 1'b0;
    capture           = 1'b0;
    abort             = 1'b0;

    case (state)
      ST_IDLE: begin
        clear_accumulator = 1'b1;
        if (start) state_next = ST_PRIME;
      end
      ST_PRIME: begin
        // The first enable seen here clears the accumulator; counting starts after.
        clear_accumulator = 1'b1;
        if (sym_clk_ena) begin
          state_next   = ST_ACCUM;
          sym_cnt_next = '0;
        end
      end
      ST_ACCUM: begin
        sym_cnt_next = sym_cnt_inc;
        if (sym_cnt_inc == WIN_LEN) state_next = ST_CLOSE;
      end
      ST_CLOSE: begin
        // Clear held across one enable: that symbol is discarded.
        clear_accumulator = 1'b1;
        if (sym_clk_ena) begin
          state_next   = ST_SETTLE;
          sym_cnt_next = '0;
          settle_next  = '0;
        end
      end
      ST_SETTLE: begin
        // Enables here already belong to the new window.
        sym_cnt_next = sym_cnt_inc;
        if (settle_cnt == SETTLE_LAST) state_next = ST_CAPTURE;
        else                           settle_next = settle_cnt + 1'b1;
      end
      ST_CAPTURE: begin
        sym_cnt_next = sym_cnt_inc;
        capture      = 1'b1;
        state_next   = ST_ACCUM;
      end
      default: begin
        clear_accumulator = 1'b1;
        state_next        = ST_IDLE;
      end
    endcase

    // Dropping start abandons the partial window from any active state.
    if ((state != ST_IDLE) && !start) begin
      state_next = ST_IDLE;
      capture    = 1'b0;
      abort      = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Variance: mean_sq - mean^2. The square of an 18-bit signed value fits in
  // 36 bits and is non-negative; the subtraction is done in 37 bits so a
  // negative mean-square cannot wrap into a large positive result.
  // --------------------------------------------------------------------------
  assign err_ext     = {{18{accumulated_error[17]}}, accumulated_error};
  assign err_square  = err_ext * err_ext;
  assign var_diff    = {accumulated_squared_error[35], accumulated_squared_error}
                     - {1'b0, err_square};
  assign var_clamped = var_diff[36] ? 36'd0 : var_diff[35:0];

  // --------------------------------------------------------------------------
  // Result registers and handshake
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mean_error     <= '0;
      mean_sq_error  <= '0;
      error_variance <= '0;
      window_count   <= '0;
      stats_valid    <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      if (capture) begin
        mean_error     <= accumulated_error;
        mean_sq_error  <= accumulated_squared_error;
        error_variance <= var_clamped;
        window_count   <= window_count + 16'd1;
        // A capture beats a same-cycle handshake, so valid stays set.
        stats_valid    <= 1'b1;
        if (stats_valid && !stats_ready) overrun <= 1'b1;
      end else if (stats_valid && stats_ready) begin
        stats_valid <= 1'b0;
      end

      if (abort) overrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_error_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_error_window_ctrl
// Purpose  : Directed self-checking bench for error_window_ctrl with a small
//            behavioural accumulator model (LOG2_M=2, ACC_SETTLE=2, symbol
//            strobe every 4 clk).
// Revision : 1.0 - initial release
// ============================================================================
module tb_error_window_ctrl;

  localparam int LOG2_M     = 2;
  localparam int ACC_SETTLE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               sym_clk_ena;
  logic               start;
  logic               stats_ready;
  logic signed [17:0] accumulated_error;
  logic signed [35:0] accumulated_squared_error;
  logic               clear_accumulator;
  logic [7:0]         shiftVal;
  logic signed [17:0] mean_error;
  logic signed [35:0] mean_sq_error;
  logic signed [35:0] error_variance;
  logic               stats_valid;
  logic [15:0]        window_count;
  logic               overrun;

  error_window_ctrl #(
    .LOG2_M     (LOG2_M),
    .ACC_SETTLE (ACC_SETTLE)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .sym_clk_ena               (sym_clk_ena),
    .start                     (start),
    .accumulated_error         (accumulated_error),
    .accumulated_squared_error (accumulated_squared_error),
    .clear_accumulator         (clear_accumulator),
    .shiftVal                  (shiftVal),
    .mean_error                (mean_error),
    .mean_sq_error             (mean_sq_error),
    .error_variance            (error_variance),
    .stats_valid               (stats_valid),
    .stats_ready               (stats_ready),
    .window_count              (window_count),
    .overrun                   (overrun)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, $signed(observed), $signed(expected));
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus controls
  // --------------------------------------------------------------------------
  int                 err_base  = 0;
  logic               alt_mode  = 1'b0;
  logic               alt_pos   = 1'b1;
  int                 err_val   = 0;
  logic               force_acc = 1'b0;
  logic signed [17:0] force_e   = '0;
  logic signed [35:0] force_sq  = '0;
  int                 phase     = 0;

  // Free-running symbol strobe, one clk high every 4 clks.
  initial begin
    sym_clk_ena = 1'b0;
    forever begin
      @(negedge clk);
      phase       = (phase + 1) % 4;
      sym_clk_ena = (phase == 0);
      if (sym_clk_ena) begin
        if (alt_mode) begin
          err_val = alt_pos ? 3 : -3;
          alt_pos = !alt_pos;
        end else begin
          err_val = err_base;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Accumulator model: sums while clear is low, zeroes on an enable seen with
  // clear high, and latches sum/2^LOG2_M when clear rises.
  // --------------------------------------------------------------------------
  int                 sum_e      = 0;
  longint             sum_sq     = 0;
  logic               clear_q    = 1'b1;
  logic signed [17:0] model_e    = '0;
  logic signed [35:0] model_sq   = '0;
  int                 clr_en_cnt = 0;

  always @(posedge clk) begin
    if (reset) begin
      sum_e    <= 0;
      sum_sq   <= 0;
      clear_q  <= 1'b1;
      model_e  <= '0;
      model_sq <= '0;
    end else begin
      if (sym_clk_ena) begin
        if (clear_accumulator) begin
          sum_e  <= 0;
          sum_sq <= 0;
        end else begin
          sum_e  <= sum_e + err_val;
          sum_sq <= sum_sq + longint'(err_val) * longint'(err_val);
        end
      end
      if (clear_accumulator && !clear_q) begin
        model_e  <= 18'(sum_e >>> LOG2_M);
        model_sq <= 36'(sum_sq >>> LOG2_M);
      end
      clear_q <= clear_accumulator;
    end
    if (sym_clk_ena && clear_accumulator) clr_en_cnt <= clr_en_cnt + 1;
  end

  assign accumulated_error         = force_acc ? force_e  : model_e;
  assign accumulated_squared_error = force_acc ? force_sq : model_sq;

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_capture(input int bound);
    logic [15:0] wc0;
    int          k;
    wc0 = window_count;
    k   = 0;
    while ((window_count == wc0) && (k < bound)) begin
      @(negedge clk);
      k++;
    end
    if (window_count == wc0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL capture_timeout: no capture within %0d clk, window_count %0d", bound, window_count);
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  int c0;

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    stats_ready = 1'b1;
    err_base    = 100;

    // 1. Reset state
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_clear",    clear_accumulator, 1);
    check("rst_shift",    shiftVal, 2);
    check("rst_valid",    stats_valid, 0);
    check("rst_wcount",   window_count, 0);
    check("rst_overrun",  overrun, 0);
    check("rst_mean",     mean_error, 0);
    check("rst_variance", error_variance, 0);

    // 2. Constant +100 error, consumer always ready
    start = 1'b1;
    wait_capture(80);
    check("const_mean",   mean_error, 100);
    check("const_meansq", mean_sq_error, 10000);
    check("const_var",    error_variance, 0);
    check("const_valid",  stats_valid, 1);
    check("const_wcount", window_count, 1);
    tick(1);
    check("const_valid_pulse", stats_valid, 0);
    c0 = clr_en_cnt;
    wait_capture(40);
    check("clear_one_enable", clr_en_cnt - c0, 1);
    check("const_wcount2",    window_count, 2);

    // 3. Alternating +3/-3; the first window after switching may mix values
    alt_mode = 1'b1;
    wait_capture(40);
    wait_capture(40);
    check("alt_mean",   mean_error, 0);
    check("alt_meansq", mean_sq_error, 9);
    check("alt_var",    error_variance, 9);

    // 4. Forced accumulator outputs: clamp, then a negative mean
    force_acc = 1'b1;
    force_e   = 18'sd10;
    force_sq  = 36'sd50;
    wait_capture(40);
    check("clamp_mean",   mean_error, 10);
    check("clamp_meansq", mean_sq_error, 50);
    check("clamp_var",    error_variance, 0);
    force_e  = -18'sd4;
    force_sq = 36'sd20;
    wait_capture(40);
    check("neg_mean", mean_error, -4);
    check("neg_var",  error_variance, 4);

    // 5. Back-pressure over two windows
    reset       = 1'b1;
    stats_ready = 1'b0;
    force_e     = 18'sd5;
    force_sq    = 36'sd25;
    tick(2);
    reset = 1'b0;
    wait_capture(80);
    check("bp_a_mean",    mean_error, 5);
    check("bp_a_valid",   stats_valid, 1);
    check("bp_a_overrun", overrun, 0);
    check("bp_a_wcount",  window_count, 1);
    force_e  = 18'sd7;
    force_sq = 36'sd49;
    wait_capture(40);
    check("bp_b_overrun", overrun, 1);
    check("bp_b_mean",    mean_error, 7);
    check("bp_b_var",     error_variance, 0);
    check("bp_b_wcount",  window_count, 2);
    check("bp_b_valid",   stats_valid, 1);
    stats_ready = 1'b1;
    tick(1);
    stats_ready = 1'b0;
    check("bp_handshake_valid",  stats_valid, 0);
    check("bp_overrun_sticky",   overrun, 1);

    // 6. Stop mid-window with a pending result, then reset while valid
    wait_capture(40);
    check("stop_pre_wcount", window_count, 3);
    check("stop_pre_valid",  stats_valid, 1);
    tick(6);
    start = 1'b0;
    tick(1);
    check("stop_clear",   clear_accumulator, 1);
    check("stop_valid",   stats_valid, 1);
    check("stop_overrun", overrun, 0);
    check("stop_wcount",  window_count, 3);
    tick(30);
    check("idle_no_capture", window_count, 3);
    check("idle_clear",      clear_accumulator, 1);
    reset = 1'b1;
    tick(1);
    check("rst2_valid",    stats_valid, 0);
    check("rst2_wcount",   window_count, 0);
    check("rst2_mean",     mean_error, 0);
    check("rst2_meansq",   mean_sq_error, 0);
    check("rst2_variance", error_variance, 0);
    check("rst2_clear",    clear_accumulator, 1);
    reset = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
